// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline MEM stage: bundle field offsets,
// load/store width encodings and the load-lane extension helper.
package riscv_pipe_pkg;

  localparam int DMEM_WORDS_DEF = 64;

  localparam int EXMEM_W     = 45;
  localparam int EX_RD_LSB   = 0;
  localparam int EX_F3_LSB   = 5;
  localparam int EX_REGWRITE = 8;
  localparam int EX_MEMTOREG = 9;
  localparam int EX_MEMREAD  = 10;
  localparam int EX_MEMWRITE = 11;
  localparam int EX_BRANCH   = 12;

  localparam int MEMWB_W     = 7;
  localparam int MB_RD_LSB   = 0;
  localparam int MB_REGWRITE = 5;
  localparam int MB_MEMTOREG = 6;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_LOAD,
    ACC_STORE
  } acc_e;

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    sel_b = word[{lane, 3'b000} +: 8];
    sel_h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{sel_b[7]}}, sel_b};
      F3_BU:   return {24'h0, sel_b};
      F3_H:    return {{16{sel_h[15]}}, sel_h};
      F3_HU:   return {16'h0, sel_h};
      F3_W:    return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-lane data memory: one 8-bit array per lane so each lane maps onto a
// block RAM with its own write enable; read data is registered.
module data_memory
  import riscv_pipe_pkg::*;
#(
  parameter int DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int WORD_AW    = $clog2(DMEM_WORDS)
) (
  input  logic               clk,
  input  logic [3:0]         i_be,
  input  logic [WORD_AW-1:0] i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [DMEM_WORDS];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
      if (i_be[gi]) begin
        r_mem[i_addr] <= i_wdata[8*gi +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end

    assign o_rdata[8*gi +: 8] = r_rdata;
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage: data memory loads/stores, branch resolution, misalignment fault
// capture and the MEM/WB pipeline register.
module memory_access
  import riscv_pipe_pkg::*;
#(
  parameter int DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int ADDR_LSB_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXMEM_W-1:0]   EXMEM,
  input  logic [31:0]          ALUresult,
  input  logic [31:0]          WRITE_DATA,
  input  logic                 Zero,
  input  logic [7:0]           PCBranch_EXMEM,
  output logic                 PCSrc,
  output logic [7:0]           PCBranch_out,
  output logic [MEMWB_W-1:0]   MEMWB,
  output logic [31:0]          MEMWB_read_data,
  output logic [31:0]          MEMWB_alu,
  output logic                 mem_fault,
  output logic [31:0]          fault_addr
);

  localparam int WORD_AW = $clog2(DMEM_WORDS);
  localparam int BYTE_AW = WORD_AW + 2;
  localparam logic [31:0] ADDR_MASK = (ADDR_LSB_W >= 32) ? 32'hFFFF_FFFF
                                    : 32'((64'd1 << ADDR_LSB_W) - 64'd1);

  logic [4:0]         w_rd;
  logic [2:0]         w_f3;
  logic               w_regwrite, w_memtoreg, w_memread, w_memwrite, w_branch;
  logic [31:0]        w_addr_masked;
  logic [BYTE_AW-1:0] w_byte_addr;
  logic [1:0]         w_lane;
  logic [WORD_AW-1:0] w_word_idx;
  acc_e               w_acc;
  logic               w_misaligned;
  logic               w_ld_ok;
  logic [3:0]         w_be;
  logic [3:0]         w_be_gated;
  logic [31:0]        w_wdata;
  logic [31:0]        w_rd_word;
  logic               w_unused_bits;

  logic [MEMWB_W-1:0] r_memwb;
  logic [31:0]        r_alu;
  logic               r_ld_valid;
  logic [2:0]         r_ld_f3;
  logic [1:0]         r_ld_lane;
  logic               r_fault;
  logic [31:0]        r_fault_addr;

  assign w_rd       = EXMEM[EX_RD_LSB +: 5];
  assign w_f3       = EXMEM[EX_F3_LSB +: 3];
  assign w_regwrite = EXMEM[EX_REGWRITE];
  assign w_memtoreg = EXMEM[EX_MEMTOREG];
  assign w_memread  = EXMEM[EX_MEMREAD];
  assign w_memwrite = EXMEM[EX_MEMWRITE];
  assign w_branch   = EXMEM[EX_BRANCH];

  assign w_addr_masked = ALUresult & ADDR_MASK;
  assign w_byte_addr   = w_addr_masked[BYTE_AW-1:0];
  assign w_lane        = w_byte_addr[1:0];
  assign w_word_idx    = w_byte_addr[BYTE_AW-1:2];

  assign w_unused_bits = ^{EXMEM[EXMEM_W-1:EX_BRANCH+1], w_addr_masked[31:BYTE_AW]};

  assign PCSrc        = w_branch & Zero;
  assign PCBranch_out = PCBranch_EXMEM;

  // A store wins over a simultaneous load; the read result is then dropped.
  always_comb begin
    w_acc        = ACC_NONE;
    w_misaligned = 1'b0;
    w_ld_ok      = 1'b0;
    w_be         = 4'b0000;
    w_wdata      = 32'h0;
    if (w_memwrite) begin
      w_acc = ACC_STORE;
    end else if (w_memread) begin
      w_acc = ACC_LOAD;
    end
    case (w_acc)
      ACC_STORE: begin
        case (w_f3)
          F3_B: begin
            w_wdata = {4{WRITE_DATA[7:0]}};
            w_be    = 4'(4'b0001 << w_lane);
          end
          F3_H: begin
            w_wdata = {2{WRITE_DATA[15:0]}};
            if (w_lane[0]) w_misaligned = 1'b1;
            else           w_be = w_lane[1] ? 4'b1100 : 4'b0011;
          end
          F3_W: begin
            w_wdata = WRITE_DATA;
            if (w_lane != 2'b00) w_misaligned = 1'b1;
            else                 w_be = 4'b1111;
          end
          default: ;
        endcase
      end
      ACC_LOAD: begin
        case (w_f3)
          F3_B, F3_BU: w_ld_ok = 1'b1;
          F3_H, F3_HU: begin
            if (w_lane[0]) w_misaligned = 1'b1;
            else           w_ld_ok = 1'b1;
          end
          F3_W: begin
            if (w_lane != 2'b00) w_misaligned = 1'b1;
            else                 w_ld_ok = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Blocking the write while rst is high keeps a store caught by reset out of memory.
  assign w_be_gated = rst ? 4'b0000 : w_be;

  data_memory #(
    .DMEM_WORDS (DMEM_WORDS),
    .WORD_AW    (WORD_AW)
  ) u_dmem (
    .clk     (clk),
    .i_be    (w_be_gated),
    .i_addr  (w_word_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memwb      <= '0;
      r_alu        <= 32'h0;
      r_ld_valid   <= 1'b0;
      r_ld_f3      <= 3'b000;
      r_ld_lane    <= 2'b00;
      r_fault      <= 1'b0;
      r_fault_addr <= 32'h0;
    end else begin
      r_memwb    <= {w_memtoreg, w_regwrite, w_rd};
      r_alu      <= ALUresult;
      r_ld_valid <= w_ld_ok;
      r_ld_f3    <= w_f3;
      r_ld_lane  <= w_lane;
      if (w_misaligned && !r_fault) begin
        r_fault      <= 1'b1;
        r_fault_addr <= ALUresult;
      end
    end
  end

  // Lane select runs on the registered RAM word, so it is ready one edge after the load.
  assign MEMWB_read_data = r_ld_valid ? load_extend(w_rd_word, r_ld_f3, r_ld_lane) : 32'h0;
  assign MEMWB           = r_memwb;
  assign MEMWB_alu       = r_alu;
  assign mem_fault       = r_fault;
  assign fault_addr      = r_fault_addr;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed vector table, reset corner
// cases and randomized traffic compared against a byte-array reference model.
module tb_memory_access;
  import riscv_pipe_pkg::*;

  localparam int MEM_BYTES = 4 * DMEM_WORDS_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [44:0]   EXMEM = '0;
  logic [31:0]   ALUresult = '0;
  logic [31:0]   WRITE_DATA = '0;
  logic          Zero = 1'b0;
  logic [7:0]    PCBranch_EXMEM = '0;
  logic          PCSrc;
  logic [7:0]    PCBranch_out;
  logic [6:0]    MEMWB;
  logic [31:0]   MEMWB_read_data;
  logic [31:0]   MEMWB_alu;
  logic          mem_fault;
  logic [31:0]   fault_addr;

  always #5 clk = ~clk;

  memory_access #(.DMEM_WORDS(DMEM_WORDS_DEF), .ADDR_LSB_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .EXMEM           (EXMEM),
    .ALUresult       (ALUresult),
    .WRITE_DATA      (WRITE_DATA),
    .Zero            (Zero),
    .PCBranch_EXMEM  (PCBranch_EXMEM),
    .PCSrc           (PCSrc),
    .PCBranch_out    (PCBranch_out),
    .MEMWB           (MEMWB),
    .MEMWB_read_data (MEMWB_read_data),
    .MEMWB_alu       (MEMWB_alu),
    .mem_fault       (mem_fault),
    .fault_addr      (fault_addr)
  );

  int total = 0;
  int bad   = 0;
  int n_txn = 0;

  // Reference model: plain byte array plus the sticky fault state.
  logic [7:0]  m_mem [MEM_BYTES];
  bit          m_fault = 1'b0;
  logic [31:0] m_faddr = '0;

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_fault;
    logic [31:0] exp_faddr;
  } vec_t;

  vec_t tbl [19];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] exp_rd);
    int unsigned baddr;
    int unsigned size;
    bit          sgn;
    logic [31:0] val;
    exp_rd = 32'h0;
    baddr  = addr % MEM_BYTES;
    size   = 0;
    sgn    = 1'b0;
    if (!rd_en && !wr_en) return;
    if (wr_en) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd4: size = 1;
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd5: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end
    if (size == 0) return;
    if (baddr % size != 0) begin
      if (!m_fault) begin
        m_fault = 1'b1;
        m_faddr = addr;
      end
      return;
    end
    if (wr_en) begin
      for (int i = 0; i < int'(size); i++) m_mem[baddr + i] = wdata[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < int'(size); i++) val = val | (32'(m_mem[baddr + i]) << (8*i));
      if (sgn && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
      exp_rd = val;
    end
  endtask

  // Starts and ends just after a rising edge; results are sampled 1 time unit past the edge.
  task automatic do_txn(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic rw, input logic m2r,
                        input logic br, input logic zr, input logic [7:0] pcb);
    logic [31:0] exp_rd;
    EXMEM          = {32'($urandom), br, wr_en, rd_en, m2r, rw, f3, rd};
    ALUresult      = addr;
    WRITE_DATA     = wdata;
    Zero           = zr;
    PCBranch_EXMEM = pcb;
    #1;
    check32("pcsrc", {31'b0, PCSrc}, {31'b0, br & zr});
    check32("pcbranch_out", {24'b0, PCBranch_out}, {24'b0, pcb});
    model_step(rd_en, wr_en, f3, addr, wdata, exp_rd);
    @(posedge clk);
    #1;
    check32("read_data", MEMWB_read_data, exp_rd);
    check32("memwb", {25'b0, MEMWB}, {25'b0, m2r, rw, rd});
    check32("memwb_alu", MEMWB_alu, addr);
    check32("mem_fault", {31'b0, mem_fault}, {31'b0, m_fault});
    check32("fault_addr", fault_addr, m_faddr);
    n_txn++;
    $display("txn %0d rd=%0b wr=%0b f3=%0d addr=%h wdata=%h -> rdata=%h memwb=%h fault=%0b faddr=%h",
             n_txn, rd_en, wr_en, f3, addr, wdata, MEMWB_read_data, MEMWB, mem_fault, fault_addr);
  endtask

  task automatic check_zero_outputs(input string tag);
    check32({tag, "_memwb"}, {25'b0, MEMWB}, 32'h0);
    check32({tag, "_read_data"}, MEMWB_read_data, 32'h0);
    check32({tag, "_alu"}, MEMWB_alu, 32'h0);
    check32({tag, "_fault"}, {31'b0, mem_fault}, 32'h0);
    check32({tag, "_fault_addr"}, fault_addr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        r_rd, r_wr, r_br, r_zr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          op;

    tbl[0]  = '{1'b0, 1'b1, F3_W,  32'h20,  32'h11223344, 32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, F3_B,  32'h21,  32'h000000AA, 32'h0,        1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, F3_W,  32'h20,  32'h0,        32'h1122AA44, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, F3_B,  32'h21,  32'h0,        32'hFFFFFFAA, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, F3_BU, 32'h21,  32'h0,        32'h000000AA, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, F3_H,  32'h32,  32'h00008001, 32'h0,        1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, F3_H,  32'h32,  32'h0,        32'hFFFF8001, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, F3_HU, 32'h32,  32'h0,        32'h00008001, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, F3_W,  32'h30,  32'h0,        32'h8001000C, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, F3_W,  32'h40,  32'h0,        32'h5A5A0010, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b1, F3_W,  32'h41,  32'hFFFFFFFF, 32'h0,        1'b1, 32'h41};
    tbl[11] = '{1'b1, 1'b0, F3_W,  32'h40,  32'h0,        32'h5A5A0010, 1'b1, 32'h41};
    tbl[12] = '{1'b1, 1'b0, F3_H,  32'h43,  32'h0,        32'h0,        1'b1, 32'h41};
    tbl[13] = '{1'b0, 1'b1, F3_W,  32'h104, 32'hCAFEF00D, 32'h0,        1'b1, 32'h41};
    tbl[14] = '{1'b1, 1'b0, F3_W,  32'h04,  32'h0,        32'hCAFEF00D, 1'b1, 32'h41};
    tbl[15] = '{1'b1, 1'b1, F3_W,  32'h48,  32'h01020304, 32'h0,        1'b1, 32'h41};
    tbl[16] = '{1'b1, 1'b0, 3'b011, 32'h48, 32'h0,        32'h0,        1'b1, 32'h41};
    tbl[17] = '{1'b0, 1'b1, 3'b100, 32'h48, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h41};
    tbl[18] = '{1'b1, 1'b0, F3_W,  32'h48,  32'h0,        32'h01020304, 1'b1, 32'h41};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero_outputs("por");
    @(posedge clk);
    #1;

    for (int i = 0; i < DMEM_WORDS_DEF; i++) begin
      do_txn(1'b0, 1'b1, F3_W, 32'(i * 4), 32'h5A5A0000 | 32'(i), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end

    // Reset handling: make every output nonzero, then reset asynchronously.
    do_txn(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_txn(1'b0, 1'b1, F3_H, 32'h13, 32'h0000FFFF, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    do_txn(1'b1, 1'b0, F3_W, 32'h10, 32'h0,        5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check32("pre_reset_read", MEMWB_read_data, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    m_fault = 1'b0;
    m_faddr = 32'h0;
    // A store presented while reset is held across an edge must not land.
    EXMEM      = {32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, F3_W, 5'd9};
    ALUresult  = 32'h10;
    WRITE_DATA = 32'h12345678;
    @(posedge clk);
    #1;
    check_zero_outputs("held_rst");
    rst = 1'b0;
    do_txn(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check32("mem_retained", MEMWB_read_data, 32'hDEADBEEF);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      do_txn(tbl[i].rd_en, tbl[i].wr_en, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
             5'(i), 1'b1, tbl[i].rd_en, 1'b0, 1'b0, 8'h00);
      check32($sformatf("tbl%0d_read", i), MEMWB_read_data, tbl[i].exp_rd);
      check32($sformatf("tbl%0d_fault", i), {31'b0, mem_fault}, {31'b0, tbl[i].exp_fault});
      check32($sformatf("tbl%0d_faddr", i), fault_addr, tbl[i].exp_faddr);
    end

    // ALU pass-through and branch resolution
    do_txn(1'b0, 1'b0, 3'b000, 32'h11111111, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h15);
    check32("alu_memwb", {25'b0, MEMWB}, 32'h25);
    check32("alu_pass", MEMWB_alu, 32'h11111111);
    Zero = 1'b1;
    EXMEM[EX_BRANCH] = 1'b1;
    PCBranch_EXMEM = 8'h15;
    #1;
    check32("branch_taken", {31'b0, PCSrc}, 32'h1);
    check32("branch_target", {24'b0, PCBranch_out}, 32'h15);
    Zero = 1'b0;
    #1;
    check32("branch_not_taken", {31'b0, PCSrc}, 32'h0);
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      op     = int'($urandom_range(0, 9));
      r_rd   = (op < 4) || (op == 9);
      r_wr   = ((op >= 4) && (op < 8)) || (op == 9);
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      r_br   = 1'($urandom);
      r_zr   = 1'($urandom);
      do_txn(r_rd, r_wr, r_f3, r_addr, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
             r_br, r_zr, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage RV32I pipeline; consumes the registered EX/MEM bundle produced by instruction_execution.
- Holds a byte-addressed data memory.
- Performs loads and stores of byte, half and word widths, resolves branches, and registers the MEM/WB bundle for writeback.
- Flags misaligned accesses with a sticky fault and captures the faulting address.

Parameters:
- DMEM_WORDS, 64, data memory depth in 32-bit words; must be a power of two.
- ADDR_LSB_W, 8, number of ALUresult bits used as the byte address; upper bits are ignored.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- EXMEM  in  45  control bundle: [4:0] rd, [7:5] funct3, [8] RegWrite, [9] MemtoReg, [10] MemRead, [11] MemWrite, [12] Branch, [44:13] reserved (ignored).
- ALUresult  in  32  effective address for loads/stores, or result for ALU ops.
- WRITE_DATA  in  32  store data (rs2).
- Zero  in  1  ALU zero flag.
- PCBranch_EXMEM  in  8  branch target.
- PCSrc  out  1  combinational: Branch & Zero.
- PCBranch_out  out  8  combinational pass-through of PCBranch_EXMEM.
- MEMWB  out  7  registered: [4:0] rd, [5] RegWrite, [6] MemtoReg.
- MEMWB_read_data  out  32  registered, extended load data.
- MEMWB_alu  out  32  registered ALUresult.
- mem_fault  out  1  sticky misalignment flag.
- fault_addr  out  32  ALUresult of the first faulting access.

Behaviour:
Reset:
- Asserting rst clears MEMWB, MEMWB_read_data, MEMWB_alu, mem_fault and fault_addr to 0, immediately (asynchronous).
- Memory contents are not reset.
- Reset asserted mid-store: that store is not performed.

Addressing:
- Byte address = ALUresult[ADDR_LSB_W-1:0] modulo (4*DMEM_WORDS).
- Word index = byte_addr[..:2].
- Out-of-range addresses wrap; they are not a fault.

Stores (MemWrite=1):
- Written at the rising edge, little-endian.
- funct3 000 SB: writes byte lane addr[1:0] with WRITE_DATA[7:0].
- funct3 001 SH: writes lanes {addr[1],0} and +1 with WRITE_DATA[15:0].
- funct3 010 SW: writes the full word.
- Other funct3 values: the store is suppressed.

Loads (MemRead=1):
- Word read at the edge; the selected lanes go to MEMWB_read_data in the same edge, so MEM→WB latency is 1 cycle.
- funct3 000 LB and 001 LH are sign-extended; 100 LBU and 101 LHU are zero-extended; 010 LW returns the word.
- Other funct3 values return 0.
- When MemRead=0, MEMWB_read_data = 0.

Misalignment (half with addr[0]=1, or word with addr[1:0]≠0):
- Store suppressed; load returns 0.
- MEMWB RegWrite is still forwarded.
- mem_fault set; fault_addr captured only when mem_fault was 0.
- Cleared only by rst.

Simultaneous MemRead and MemWrite:
- The store takes priority; MEMWB_read_data = 0.

Ordering:
- Store at edge N followed by a load of the same address at edge N+1 returns the new data.
- No bypass is needed within one cycle, since one instruction is in flight per cycle.

Other:
- EXMEM[44:13] is ignored.
- MEMWB_alu and MEMWB are latched every edge, regardless of instruction type.

Decomposition:
- Package riscv_pipe_pkg holds:
  - EXMEM field offsets and MEMWB field offsets.
  - funct3 constants F3_B/H/W/BU/HU.
  - Default DMEM_WORDS.
- Sub-module data_memory holds the word array, the byte-enable write and the synchronous word read.
- Lane select, extension, fault logic and the MEMWB register stay in memory_access.

Test Plan:
- Reset handling: write 0xDEADBEEF to addr 0x10, pulse rst → MEMWB, MEMWB_read_data, mem_fault, fault_addr all 0 immediately; then LW 0x10 returns 0xDEADBEEF (memory retained).
- Byte lanes: SW 0x11223344 @0x20; SB 0xAA @0x21 → LW 0x20 = 0x1122AA44; LB 0x21 = 0xFFFFFFAA; LBU 0x21 = 0x000000AA.
- Half lanes: SH 0x8001 @0x32 → LH 0x32 = 0xFFFF8001; LHU 0x32 = 0x00008001; LW 0x30 shows 0x8001 in the upper half.
- Misalignment: SW @0x41 → memory unchanged, mem_fault=1, fault_addr=0x41; then LH @0x43 → read_data 0, fault_addr stays 0x41.
- Branch: Branch=1, Zero=1, PCBranch_EXMEM=0x15 → PCSrc=1, PCBranch_out=0x15 in the same cycle; Zero=0 → PCSrc=0.
- Wrap and pass-through: ALU op (RegWrite=1, rd=5, ALUresult=0x11111111) → next edge MEMWB rd=5, RegWrite=1, MEMWB_alu=0x11111111; SW @0x104 with ADDR_LSB_W=8 aliases to 0x04, confirmed by LW 0x04.
